serial_frame_sender: RTL
========================

SERIAL_FRAME_SENDER -- requirements
Module: serial_frame_sender

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; no other clock or asynchronous reset SHALL exist.
REQ-002 Port list (name, direction, width, meaning):
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- clkEn  input  1  bit-period enable; the FSM and shifter advance only on clk edges with clkEn=1
- start  input  1  frame request, sampled in IDLE
- portNum  input  2  destination port field
- len  input  4  number of data bits, 0..15
- data  input  15  payload, data[0] sent first
- SerOut  output  1  serial line, idles high
- Busy  output  1  high while a frame is in progress
- DataValid  output  1  high while SerOut carries a payload bit
- Done  output  1  frame-complete indication

Function
REQ-003 Frame format on SerOut SHALL be: start bit 0; portNum MSB first (2 bits); len MSB first (4 bits); then len payload bits, data[0] first, data[len-1] last.
REQ-004 Total bit periods per frame SHALL be 7+len, from 7 to 22.
REQ-005 FSM states SHALL be IDLE, START, PORT, LEN, DATA and DONE; a state change SHALL occur only on a clk edge with clkEn=1.
REQ-006 IDLE->START SHALL occur on a clkEn edge with start=1. On that edge:
- portNum, len and data SHALL be latched.
- SerOut SHALL become 0.
REQ-007 In IDLE with start=0 the FSM SHALL hold; start pulses on edges with clkEn=0 SHALL be ignored.
REQ-008 Each state SHALL hold SerOut for exactly one clkEn period per bit:
- START: 1 bit.
- PORT: 2 bits, counter 1..0.
- LEN: 4 bits, counter 3..0.
- DATA: len bits, counter 0..len-1.
REQ-009 START->PORT, PORT->LEN and LEN->DATA SHALL occur after the last bit of the current state.
REQ-010 If the latched len=0, LEN SHALL go directly to DONE and DATA SHALL be skipped.
REQ-011 DATA->DONE SHALL occur on the clkEn edge after payload bit len-1 has been held.
REQ-012 Entering DONE SHALL set SerOut=1 and Done=1.
REQ-013 DONE->IDLE SHALL occur on the next clkEn edge; Done SHALL be high for exactly one clkEn period.
REQ-014 Busy SHALL be 1 in START, PORT, LEN, DATA and DONE, and 0 in IDLE.
REQ-015 DataValid SHALL be 1 only in DATA.
REQ-016 A start asserted while Busy=1 SHALL be ignored.
REQ-017 Changes on portNum, len or data during a frame SHALL NOT affect the frame in progress.
REQ-018 start=1 on the DONE->IDLE edge SHALL NOT begin a frame; the earliest new frame SHALL begin on the following clkEn edge.
REQ-019 All outputs SHALL be registered and SHALL NOT change on edges with clkEn=0.
REQ-020 Bit counters SHALL be 4 bits wide and SHALL NOT wrap within a frame.

Reset
REQ-021 On any clk edge with rst=1, independent of clkEn, the block SHALL enter IDLE and set SerOut=1, Busy=0, DataValid=0, Done=0, and clear all counters and latches.
REQ-022 rst SHALL take priority over start and clkEn.
REQ-023 A reset mid-frame SHALL abort the frame, leave the line high, and SHALL NOT assert Done.

Verification
REQ-024 clkEn=1 every cycle, portNum=2'b10, len=4'd3, data=15'b101, start pulsed: SerOut sequence 0,1,0,0,0,1,1,1,0,1; Done high in period 11; Busy high periods 1-11.
REQ-025 len=0, portNum=2'b01: SerOut sequence 0,0,1,0,0,0,0; DataValid never 1; Done in period 8.
REQ-026 clkEn high every 4th cycle, len=15: the frame spans 23x4 clk cycles; outputs are stable between enables; DataValid is high for 15 periods.
REQ-027 start re-pulsed and data changed in the middle of DATA: the frame is unchanged and no second frame starts.
REQ-028 rst asserted during LEN: the next edge gives SerOut=1, Busy=0, and Done never asserts; a new start afterwards produces a correct frame.
REQ-029 start held high continuously: frames run back to back, separated by the DONE period and one IDLE period.

Source files
------------

// File: rtl/serial_frame_sender.sv
// Serial frame transmitter: start bit, 2-bit port, 4-bit length (MSB first),
// then 0..15 payload bits LSB first, followed by a one-period Done marker.
module serial_frame_sender (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkEn,
    input  logic        start,
    input  logic [1:0]  portNum,
    input  logic [3:0]  len,
    input  logic [14:0] data,
    output logic        SerOut,
    output logic        Busy,
    output logic        DataValid,
    output logic        Done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        PORT,
        LEN,
        DATA,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cnt_dec, cnt_inc;
    logic [1:0]  port_q, port_d;
    logic [3:0]  len_q, len_d;
    logic [14:0] data_q, data_d;
    logic        ser_q, ser_d;
    logic        busy_q, busy_d;
    logic        dv_q, dv_d;
    logic        done_q, done_d;

    // Outputs are computed for the state being entered so they are all registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        len_d   = len_q;
        data_d  = data_q;
        ser_d   = ser_q;
        busy_d  = busy_q;
        dv_d    = dv_q;
        done_d  = done_q;
        cnt_dec = cnt_q - 4'd1;
        cnt_inc = cnt_q + 4'd1;

        if (clkEn) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = START;
                        port_d  = portNum;
                        len_d   = len;
                        data_d  = data;
                        ser_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                START: begin
                    state_d = PORT;
                    cnt_d   = 4'd1;
                    ser_d   = port_q[1];
                end
                PORT: begin
                    if (cnt_q == 4'd0) begin
                        state_d = LEN;
                        cnt_d   = 4'd3;
                        ser_d   = len_q[3];
                    end else begin
                        cnt_d   = cnt_dec;
                        ser_d   = port_q[0];
                    end
                end
                LEN: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d   = cnt_dec;
                        ser_d   = len_q[cnt_dec[1:0]];
                    end else if (len_q == 4'd0) begin
                        state_d = DONE;
                        ser_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DATA;
                        cnt_d   = 4'd0;
                        ser_d   = data_q[0];
                        dv_d    = 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == len_q - 4'd1) begin
                        state_d = DONE;
                        cnt_d   = 4'd0;
                        ser_d   = 1'b1;
                        dv_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                        ser_d   = data_q[cnt_inc];
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    ser_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    ser_d   = 1'b1;
                    busy_d  = 1'b0;
                    dv_d    = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            port_q  <= 2'd0;
            len_q   <= 4'd0;
            data_q  <= 15'd0;
            ser_q   <= 1'b1;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            len_q   <= len_d;
            data_q  <= data_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
        end
    end

    assign SerOut    = ser_q;
    assign Busy      = busy_q;
    assign DataValid = dv_q;
    assign Done      = done_q;

endmodule
